uart_echo_buffer: RTL and testbench
===================================

// Module: uart_echo_buffer
// PURPOSE
//  Sits between uart_rx (rx_done/rx_data) and uart_tx (tx_start/tx_data/tx_done) in uart_top.
//  Buffers received bytes in a FIFO and replays each one to the transmitter in order.
//  Replaces the single-register echo path, which loses bytes whenever rx outpaces tx.
// PARAMETERS
//  DATA_W  8  byte width
//  ADDR_W  4  FIFO address width; DEPTH = 2**ADDR_W = 16 entries
// PORTS
//  clk         in   1         system clock, 50 MHz
//  reset       in   1         asynchronous, active-low reset (0 = reset asserted)
//  rx_done     in   1         1-cycle strobe from uart_rx: rx_data valid
//  rx_data     in   DATA_W    received byte
//  tx_done     in   1         1-cycle strobe from uart_tx: frame finished
//  tx_start    out  1         1-cycle strobe to uart_tx
//  tx_data     out  DATA_W    byte to transmit; held stable from tx_start until next pop
//  fifo_count  out  ADDR_W+1  occupancy, 0..DEPTH
//  overflow    out  1         sticky: a byte was dropped because the FIFO was full
//  clear_ovf   in   1         synchronous clear of overflow
//  busy        out  1         1 when state != IDLE or fifo_count != 0
// BEHAVIOUR
//  Reset (async, reset==0): wr_ptr=rd_ptr=0, fifo_count=0, state=IDLE, tx_start=0,
//   tx_data=0, overflow=0. Memory contents are not cleared. All outputs are registered.
//  Push: rx_done=1 and fifo_count<DEPTH -> mem[wr_ptr]<=rx_data, wr_ptr++ (wraps mod DEPTH).
//  Full: rx_done=1 and fifo_count==DEPTH -> byte dropped, overflow<=1. Drop applies even
//   if a pop occurs in the same cycle.
//  Pointers are ADDR_W bits wide and wrap. fifo_count is tracked separately:
//   +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//  FSM (2 states):
//   IDLE: if fifo_count!=0, then at the clock edge: tx_data<=mem[rd_ptr], rd_ptr++,
//         tx_start<=1, go to WAIT. Otherwise tx_start=0.
//   WAIT: tx_start<=0. tx_done is ignored in the first WAIT cycle (the cycle tx_start is high).
//         Afterwards, tx_done=1 -> IDLE. No timeout.
//  Latency: rx_done at edge E0 into an empty FIFO with FSM in IDLE -> tx_start high in the
//   cycle after E1 (2 edges). Back-to-back frames: next tx_start follows 1 cycle after IDLE
//   is re-entered.
//  A push into an empty FIFO while in IDLE is not visible until the next cycle (no bypass).
//  overflow: set has priority over clear_ovf in the same cycle.
//  Reset mid-frame: FSM aborts and buffered bytes are discarded. uart_tx is reset by the
//   same net.
//  tx_start is never asserted while in WAIT: at most one outstanding frame.
// CONFIGURATION
//  UART_ECHO_STATS_EN defined: adds outputs rx_cnt, tx_cnt, drop_cnt (each 16 bits).
//   rx_cnt  +1 per rx_done (accepted or dropped)
//   tx_cnt  +1 per tx_start
//   drop_cnt +1 per dropped byte
//   All three wrap at 2**16, clear on reset, and do not saturate.
//  UART_ECHO_STATS_EN undefined: these ports and counters do not exist; all other
//   behaviour is identical.
// TESTING
//  1 Single byte: rx_done with 0xA5, tx_done returned after 100 cycles -> exactly one
//    tx_start, tx_data=0xA5; fifo_count 1->0; busy drops after tx_done.
//  2 Burst: 3 rx_done strobes (0x3C,0xFF,0x00), 5 cycles apart, tx busy -> three tx_start
//    in order 0x3C,0xFF,0x00, each only after the previous tx_done.
//  3 Overflow: hold tx_done low, push 17 bytes 0x00..0x10 -> fifo_count=16, overflow=1,
//    0x10 lost. Release tx_done -> 16 frames 0x00..0x0F, then idle.
//    clear_ovf -> overflow=0.
//  4 Simultaneous: fifo_count=1 in IDLE, rx_done coincides with pop -> fifo_count stays 1;
//    both bytes transmitted in order.
//  5 Reset mid-operation: 4 bytes buffered, assert reset in WAIT -> tx_start=0, tx_data=0,
//    fifo_count=0, overflow=0 immediately. After release, no frames until new rx_done.
//  6 With UART_ECHO_STATS_EN defined: rerun test 3 -> rx_cnt=17, tx_cnt=16, drop_cnt=1.

Source files
------------

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: 16-entry FIFO between uart_rx and uart_tx that replays every received byte in order.
// Define UART_ECHO_STATS_EN to add the 16-bit rx_cnt / tx_cnt / drop_cnt counters.
//
// state | meaning
// IDLE  | no frame outstanding; pops the FIFO head into tx_data when non-empty
// WAIT  | one frame handed to uart_tx; waiting for its tx_done
module uart_echo_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              clear_ovf,
    output logic              busy
`ifdef UART_ECHO_STATS_EN
    ,
    output logic [15:0]       rx_cnt,
    output logic [15:0]       tx_cnt,
    output logic [15:0]       drop_cnt
`endif
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              drop;
    logic              pop;
    logic [ADDR_W:0]   count_next;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a byte.
    assign push = rx_done && (fifo_count != FULL);
    assign drop = rx_done && (fifo_count == FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx_start is high exactly in the first WAIT cycle, which is when tx_done must be ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_next = WAIT;
            WAIT:    if (!tx_start && tx_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop = (state == IDLE) && (fifo_count != '0);
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            tx_start   <= pop;
            fifo_count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            busy <= (state_next != IDLE) || (count_next != '0);
        end
    end

`ifdef UART_ECHO_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (rx_done) rx_cnt   <= rx_cnt + 16'd1;
            if (pop)     tx_cnt   <= tx_cnt + 16'd1;
            if (drop)    drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: expected frames are queued as bytes are sent and
// popped by an independent monitor on every tx_start; a responder plays uart_tx.
module tb_uart_echo_buffer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       busy;
`ifdef UART_ECHO_STATS_EN
    logic [15:0] rx_cnt;
    logic [15:0] tx_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int frames = 0;
    int n_rx = 0;
    int n_drop = 0;
    bit hold_tx = 1'b0;
    bit rand_delay = 1'b0;
    int tx_delay = 3;
    bit outstanding = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_echo_buffer dut (
        .clk(clk),
        .reset(reset),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .tx_done(tx_done),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .clear_ovf(clear_ovf),
        .busy(busy)
`ifdef UART_ECHO_STATS_EN
        ,
        .rx_cnt(rx_cnt),
        .tx_cnt(tx_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Each call occupies one clock edge: the values set here are sampled at the next edge.
    task automatic drive(input bit v, input logic [7:0] b, input bit exp_drop, input bit clr);
        @(posedge clk);
        #1;
        rx_done   = v;
        rx_data   = b;
        clear_ovf = clr;
        if (v) begin
            n_rx++;
            if (exp_drop) n_drop++;
            else exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !outstanding) break;
        end
        check("drain_busy", busy, 0);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_stats();
`ifdef UART_ECHO_STATS_EN
        check("rx_cnt", rx_cnt, n_rx);
        check("tx_cnt", tx_cnt, frames);
        check("drop_cnt", drop_cnt, n_drop);
`endif
    endtask

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            outstanding = 1'b0;
        end else if (tx_start) begin
            check("tx_overlap", outstanding, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected got %0h exp none", tx_data);
            end else begin
                check("tx_data", tx_data, exp_q.pop_front());
            end
            frames++;
            outstanding = 1'b1;
            last_data   = tx_data;
        end else if (outstanding) begin
            check("tx_hold", tx_data, last_data);
            if (tx_done) outstanding = 1'b0;
        end
    end

    // uart_tx stand-in: answers each tx_start with a one-cycle tx_done after a delay
    initial forever begin
        @(negedge clk);
        if (reset && tx_start) begin
            int d;
            d = rand_delay ? int'($urandom_range(1, 25)) : tx_delay;
            repeat (d) @(posedge clk);
            for (int i = 0; i < 20000 && hold_tx; i++) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    initial begin
        int f0;
        int len;

        // Reset state
        @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single byte with a slow transmitter
        tx_delay = 100;
        f0 = frames;
        drive(1, 8'hA5, 0, 0);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_no_bypass", tx_start, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_tx_start", tx_start, 1);
        check("t1_count_after_pop", fifo_count, 0);
        wait_idle(500);
        check("t1_frames", frames - f0, 1);

        // Burst of three, five cycles apart, while the transmitter is busy
        tx_delay = 30;
        f0 = frames;
        drive(1, 8'h3C, 0, 0);
        repeat (4) drive(0, 8'h00, 0, 0);
        drive(1, 8'hFF, 0, 0);
        repeat (4) drive(0, 8'h00, 0, 0);
        drive(1, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        wait_idle(500);
        check("t2_frames", frames - f0, 3);

        // Push coinciding with a pop keeps the count at one
        tx_delay = 5;
        f0 = frames;
        drive(1, 8'h41, 0, 0);
        drive(1, 8'h42, 0, 0);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        check("t4_count", fifo_count, 1);
        check("t4_tx_start", tx_start, 1);
        wait_idle(500);
        check("t4_frames", frames - f0, 2);

        // Overflow: one frame parked in flight, then 17 more bytes; the 17th is dropped
        hold_tx = 1'b1;
        tx_delay = 3;
        f0 = frames;
        drive(1, 8'h77, 0, 0);
        drive(0, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i <= 16; i++) drive(1, 8'(i), i == 16, 0);
        drive(1, 8'h11, 1, 1);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        check("t3_count_full", fifo_count, 16);
        check("t3_overflow_set_over_clear", overflow, 1);
        check("t3_busy", busy, 1);
        hold_tx = 1'b0;
        wait_idle(5000);
        check("t3_frames", frames - f0, 17);
        check("t3_overflow_sticky", overflow, 1);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        check("t3_overflow_cleared", overflow, 0);
        check_stats();

        // Reset while a frame is outstanding and four bytes are buffered
        hold_tx = 1'b1;
        for (int i = 0; i < 5; i++) drive(1, 8'h51 + 8'(i), 0, 0);
        drive(0, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        check("t5_count_before", fifo_count, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        check("t5_tx_start", tx_start, 0);
        check("t5_tx_data", tx_data, 0);
        check("t5_count", fifo_count, 0);
        check("t5_overflow", overflow, 0);
        check("t5_busy", busy, 0);
        hold_tx = 1'b0;
        frames = 0;
        n_rx = 0;
        n_drop = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (50) @(negedge clk);
        check("t5_no_frames", frames, 0);
        check("t5_idle", busy, 0);

        // Random bursts of at most 15 bytes, so the FIFO can never fill
        rand_delay = 1'b1;
        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(1, 15);
            for (int i = 0; i < len; i++) begin
                drive(1, 8'($urandom), 0, 0);
                repeat ($urandom_range(0, 6)) drive(0, 8'h00, 0, 0);
            end
            drive(0, 8'h00, 0, 0);
            wait_idle(3000);
        end
        check("rand_no_overflow", overflow, 0);
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
